// File: rtl/key_debouncer_rpt_pkg.sv
// Shared encodings for the multi-channel key debouncer: MODE values, per-channel
// FSM states and the counter-width helper.
package key_debouncer_rpt_pkg;

   typedef logic [1:0] mode_t;
   typedef logic [1:0] state_t;

   localparam logic [1:0] MODE_PLAIN = 2'b00;
   localparam logic [1:0] MODE_TGL   = 2'b01;
   localparam logic [1:0] MODE_RPT   = 2'b10;
   localparam logic [1:0] MODE_RPTD  = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_HOLD = 2'b01;
   localparam logic [1:0] ST_DLY  = 2'b10;
   localparam logic [1:0] ST_RPT  = 2'b11;

   // Counter must hold values up to max(DLY_CNT, RPT_CNT).
   function automatic int cnt_width(input int dly, input int rpt);
      int max_v;
      max_v = (dly > rpt) ? dly : rpt;
      return $clog2(max_v + 1);
   endfunction

endpackage

// File: rtl/key_debouncer_rpt_key_chan_fsm.sv
// One debouncer channel: shift-register filter with hysteresis, press/release
// pulses, toggle flop and the repeat / repeat-with-delay FSM.
module key_chan_fsm
   import key_debouncer_rpt_pkg::*;
#(
   parameter int L_BIT   = 4,
   parameter int DLY_CNT = 8,
   parameter int RPT_CNT = 3,
   parameter int CNT_W   = 4
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       CE,
   input  logic       S_IN,
   input  logic [1:0] MODE,
   output logic       KEY_EN,
   output logic       KEY_UP,
   output logic       KEY_DN,
   output logic       KEY_TGL
);

   localparam logic [CNT_W-1:0] DLY_TERM = CNT_W'(DLY_CNT - 1);
   localparam logic [CNT_W-1:0] RPT_TERM = CNT_W'(RPT_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_ZERO + {{(CNT_W-1){1'b0}}, 1'b1};

   // Only the newest L_BIT-1 samples are kept; the oldest bit of the window
   // would be shifted out before it is ever looked at again.
   logic [L_BIT-2:0] hist_r;
   logic [L_BIT-1:0] pn_s;
   logic             en_r, up_r, dn_r, tgl_r;
   logic [1:0]       state_r;
   logic [CNT_W-1:0] cnt_r;

   logic             press_s, release_s;
   logic [CNT_W-1:0] term_s;
   logic             en_s, up_s, dn_s, tgl_s;
   logic [1:0]       state_s;
   logic [CNT_W-1:0] cnt_s;

   assign pn_s      = {hist_r, S_IN};
   assign press_s   = ~en_r & (&pn_s);
   assign release_s = en_r & ~(|pn_s);
   assign term_s    = (state_r == ST_DLY) ? DLY_TERM : RPT_TERM;

   // Next-state decode for one CE tick; release has priority over a repeat.
   always_comb begin
      en_s    = en_r;
      up_s    = 1'b0;
      dn_s    = 1'b0;
      tgl_s   = tgl_r;
      state_s = state_r;
      cnt_s   = cnt_r;
      if (press_s) begin
         en_s  = 1'b1;
         up_s  = 1'b1;
         cnt_s = CNT_ZERO;
         if (MODE == MODE_TGL) begin
            tgl_s = ~tgl_r;
         end else begin
            tgl_s = tgl_r;
         end
         case (MODE)
            MODE_PLAIN: state_s = ST_HOLD;
            MODE_TGL:   state_s = ST_HOLD;
            MODE_RPT:   state_s = ST_RPT;
            MODE_RPTD:  state_s = ST_DLY;
            default:    state_s = ST_HOLD;
         endcase
      end else if (release_s) begin
         en_s    = 1'b0;
         dn_s    = 1'b1;
         state_s = ST_IDLE;
         cnt_s   = CNT_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: state_s = ST_IDLE;
            ST_HOLD: state_s = ST_HOLD;
            ST_DLY, ST_RPT: begin
               if (cnt_r == term_s) begin
                  up_s    = 1'b1;
                  cnt_s   = CNT_ZERO;
                  state_s = ST_RPT;
               end else begin
                  cnt_s   = cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_s = ST_IDLE;
               cnt_s   = CNT_ZERO;
            end
         endcase
      end
   end

   // Channel state register; pulses are cleared on every non-CE edge.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         hist_r  <= {(L_BIT-1){1'b0}};
         en_r    <= 1'b0;
         up_r    <= 1'b0;
         dn_r    <= 1'b0;
         tgl_r   <= 1'b0;
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
      end else if (CE) begin
         hist_r  <= pn_s[L_BIT-2:0];
         en_r    <= en_s;
         up_r    <= up_s;
         dn_r    <= dn_s;
         tgl_r   <= tgl_s;
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end else begin
         up_r    <= 1'b0;
         dn_r    <= 1'b0;
      end
   end

   assign KEY_EN  = en_r;
   assign KEY_UP  = up_r;
   assign KEY_DN  = dn_r;
   assign KEY_TGL = tgl_r;

endmodule

// File: rtl/key_debouncer_rpt.sv
// N_CH-channel key debouncer with toggle, repeat and repeat-with-delay modes;
// one key_chan_fsm per channel sharing clock, reset, CE and MODE.
module key_debouncer_rpt
   import key_debouncer_rpt_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int L_BIT   = 4,
   parameter int DLY_CNT = 8,
   parameter int RPT_CNT = 3
) (
   input  logic            CLK,
   input  logic            CLR,
   input  logic            CE,
   input  logic [N_CH-1:0] S_IN,
   input  logic [1:0]      MODE,
   output logic [N_CH-1:0] KEY_EN,
   output logic [N_CH-1:0] KEY_UP,
   output logic [N_CH-1:0] KEY_DN,
   output logic [N_CH-1:0] KEY_TGL
);

   localparam int CNT_W = cnt_width(DLY_CNT, RPT_CNT);

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      key_chan_fsm #(
         .L_BIT   (L_BIT),
         .DLY_CNT (DLY_CNT),
         .RPT_CNT (RPT_CNT),
         .CNT_W   (CNT_W)
      ) u_chan (
         .CLK     (CLK),
         .CLR     (CLR),
         .CE      (CE),
         .S_IN    (S_IN[ch]),
         .MODE    (MODE),
         .KEY_EN  (KEY_EN[ch]),
         .KEY_UP  (KEY_UP[ch]),
         .KEY_DN  (KEY_DN[ch]),
         .KEY_TGL (KEY_TGL[ch])
      );
   end

endmodule

// File: tb/tb_key_debouncer_rpt.sv
// Directed bench for key_debouncer_rpt: a run-length based channel model pushes
// expected outputs to a scoreboard queue; each edge pops and compares.
module tb_key_debouncer_rpt;

   localparam int N_CH    = 4;
   localparam int L_BIT   = 4;
   localparam int DLY_CNT = 8;
   localparam int RPT_CNT = 3;

   logic            CLK = 1'b0;
   logic            CLR;
   logic            CE;
   logic [N_CH-1:0] S_IN;
   logic [1:0]      MODE;
   logic [N_CH-1:0] KEY_EN, KEY_UP, KEY_DN, KEY_TGL;

   key_debouncer_rpt #(
      .N_CH(N_CH), .L_BIT(L_BIT), .DLY_CNT(DLY_CNT), .RPT_CNT(RPT_CNT)
   ) dut (
      .CLK(CLK), .CLR(CLR), .CE(CE), .S_IN(S_IN), .MODE(MODE),
      .KEY_EN(KEY_EN), .KEY_UP(KEY_UP), .KEY_DN(KEY_DN), .KEY_TGL(KEY_TGL)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;
   int up0_cnt;
   logic [4*N_CH-1:0] sb_q[$];

   int              run1[N_CH];
   int              run0[N_CH];
   int              tk[N_CH];
   logic [1:0]      pm[N_CH];
   logic [N_CH-1:0] m_en, m_up, m_dn, m_tgl;

   task automatic model_reset();
      for (int ch = 0; ch < N_CH; ch++) begin
         run1[ch] = 0; run0[ch] = 0; tk[ch] = 0; pm[ch] = 2'b00;
      end
      m_en = 4'b0; m_up = 4'b0; m_dn = 4'b0; m_tgl = 4'b0;
   endtask

   task automatic model_step();
      m_up = 4'b0;
      m_dn = 4'b0;
      if (CE) begin
         for (int ch = 0; ch < N_CH; ch++) begin
            if (S_IN[ch]) begin
               run0[ch] = 0;
               if (run1[ch] < L_BIT) run1[ch]++;
            end else begin
               run1[ch] = 0;
               if (run0[ch] < L_BIT) run0[ch]++;
            end
            if (!m_en[ch] && run1[ch] == L_BIT) begin
               m_en[ch] = 1'b1; m_up[ch] = 1'b1; tk[ch] = 0; pm[ch] = MODE;
               if (MODE == 2'b01) m_tgl[ch] = ~m_tgl[ch];
            end else if (m_en[ch] && run0[ch] == L_BIT) begin
               m_en[ch] = 1'b0; m_dn[ch] = 1'b1;
            end else if (m_en[ch]) begin
               tk[ch]++;
               if (pm[ch] == 2'b10 && tk[ch] % RPT_CNT == 0) m_up[ch] = 1'b1;
               if (pm[ch] == 2'b11 && tk[ch] >= DLY_CNT && (tk[ch] - DLY_CNT) % RPT_CNT == 0)
                  m_up[ch] = 1'b1;
            end
         end
      end
   endtask

   task automatic step(input logic ce_v, input logic [N_CH-1:0] s_v, input string tag);
      logic [4*N_CH-1:0] exp_v, got_v;
      CE = ce_v;
      S_IN = s_v;
      model_step();
      sb_q.push_back({m_en, m_up, m_dn, m_tgl});
      @(posedge CLK);
      #1;
      exp_v = sb_q.pop_front();
      got_v = {KEY_EN, KEY_UP, KEY_DN, KEY_TGL};
      if (KEY_UP[0]) up0_cnt++;
      total++;
      assert (got_v === exp_v) else begin
         bad++;
         $error("FAIL %s: observed en/up/dn/tgl=%h expected=%h", tag, got_v, exp_v);
      end
   endtask

   // One CE tick followed by three idle clocks.
   task automatic slow_tick(input logic [N_CH-1:0] s_v, input string tag);
      step(1'b1, s_v, tag);
      for (int k = 0; k < 3; k++) step(1'b0, s_v, tag);
   endtask

   task automatic check(input logic [31:0] got, input logic [31:0] exp_v, input string tag);
      total++;
      assert (got === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp_v);
      end
   endtask

   initial begin
      logic [6:0] glitch_seq;
      int first_up0, first_up1;
      CLR = 1'b1; CE = 1'b0; S_IN = 4'b0; MODE = 2'b00;
      model_reset();
      #12;
      check({16'h0, KEY_EN, KEY_UP, KEY_DN, KEY_TGL}, 32'd0, "reset_outputs");
      CLR = 1'b0;
      @(posedge CLK); #1;

      // 1: filter rejects a short run, press on 4th consecutive one
      glitch_seq = 7'b1101111;
      for (int i = 6; i >= 0; i--) step(1'b1, {3'b000, glitch_seq[i]}, "filter");
      step(1'b1, 4'b0001, "filter_hold");
      step(1'b1, 4'b0001, "filter_hold");

      // 2: single-zero glitch held through, then clean release
      step(1'b1, 4'b0000, "hyst_glitch");
      step(1'b1, 4'b0001, "hyst_hold");
      step(1'b1, 4'b0001, "hyst_hold");
      for (int i = 0; i < 5; i++) step(1'b1, 4'b0000, "release");

      // 3: toggle mode, then plain mode freezes the toggle
      MODE = 2'b01;
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 5; i++) step(1'b1, 4'b0001, "tgl_press");
         for (int i = 0; i < 5; i++) step(1'b1, 4'b0000, "tgl_release");
      end
      check({31'd0, KEY_TGL[0]}, 32'd1, "tgl_after3");
      MODE = 2'b00;
      for (int i = 0; i < 5; i++) step(1'b1, 4'b0001, "tgl_frozen");
      for (int i = 0; i < 5; i++) step(1'b1, 4'b0000, "tgl_frozen");
      check({31'd0, KEY_TGL[0]}, 32'd1, "tgl_frozen_val");

      // 4: repeat-with-delay then plain repeat, CE every 4 clocks
      MODE = 2'b11;
      up0_cnt = 0;
      for (int i = 0; i < L_BIT + 20; i++) slow_tick(4'b0001, "rptd_hold");
      check(up0_cnt, 32'd6, "rptd_pulses");
      for (int i = 0; i < 5; i++) slow_tick(4'b0000, "rptd_release");
      MODE = 2'b10;
      up0_cnt = 0;
      for (int i = 0; i < L_BIT + 18; i++) slow_tick(4'b0001, "rpt_hold");
      check(up0_cnt, 32'd7, "rpt_pulses");
      for (int i = 0; i < 5; i++) slow_tick(4'b0000, "rpt_release");

      // 5: release lands on the first repeat tick
      MODE = 2'b11;
      for (int i = 0; i < L_BIT + 4; i++) step(1'b1, 4'b0001, "term_hold");
      for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, "term_release");
      check({30'd0, KEY_DN[0], KEY_UP[0]}, 32'd2, "term_dn_wins");
      up0_cnt = 0;
      for (int i = 0; i < L_BIT + 8; i++) step(1'b1, 4'b0001, "term_repress");
      check(up0_cnt, 32'd2, "term_restart_dly");
      for (int i = 0; i < 5; i++) step(1'b1, 4'b0000, "term_release2");

      // 6: async reset mid-hold, then two channels with offset phases
      MODE = 2'b00;
      for (int i = 0; i < 6; i++) step(1'b1, 4'b0011, "pre_clr");
      #2 CLR = 1'b1;
      #1;
      check({16'h0, KEY_EN, KEY_UP, KEY_DN, KEY_TGL}, 32'd0, "async_clr");
      model_reset();
      #1 CLR = 1'b0;
      first_up0 = 0;
      first_up1 = 0;
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, (i >= 3) ? 4'b0011 : 4'b0001, "post_clr");
         if (KEY_UP[0] && first_up0 == 0) first_up0 = i;
         if (KEY_UP[1] && first_up1 == 0) first_up1 = i;
      end
      check(first_up0, 32'd4, "post_clr_ch0_tick");
      check(first_up1, 32'd6, "post_clr_ch1_tick");
      for (int i = 0; i < 5; i++) step(1'b1, 4'b0000, "final_release");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_debouncer_rpt.md
Name: key_debouncer_rpt

Overview:
N_CH-channel key debouncer. Each channel has a shift-register filter with hysteresis, press and release event pulses, a toggle output and optional auto-repeat with a configurable initial delay. It sits between the raw (already synchronised) key inputs and the keypad/UI logic. It replaces the single-channel switch controller and adds toggle, repeat and repeat-with-delay modes.

Parameters:
N_CH, 4, number of independent key channels
L_BIT, 4, filter length in CE ticks (min 2)
DLY_CNT, 8, CE ticks from the press event to the first repeat in mode 11 (min 1)
RPT_CNT, 3, CE ticks between repeats (min 2)
CNT_W, derived localparam, clog2(max(DLY_CNT,RPT_CNT)+1)

Ports:
CLK  in  1  system clock
CLR  in  1  asynchronous active-high reset
CE  in  1  sample enable tick; one CLK cycle wide
S_IN  in  N_CH  raw key levels, 1 = pressed
MODE  in  2  00 plain, 01 toggle, 10 repeat, 11 repeat-with-delay; shared by all channels
KEY_EN  out  N_CH  debounced pressed level
KEY_UP  out  N_CH  one-cycle pulse on press and on each repeat
KEY_DN  out  N_CH  one-cycle pulse on release
KEY_TGL  out  N_CH  toggle state

Behaviour:
- Reset: CLR=1 asynchronously clears all state. That covers P (per-channel L_BIT shift register), KEY_EN, KEY_UP, KEY_DN, KEY_TGL, the counter and the FSM (IDLE). Outputs go to 0 with no clock edge required.
- All state changes occur only at CLK edges with CE=1. The exception is KEY_UP/KEY_DN, which are forced to 0 at every edge with CE=0. A pulse therefore lasts exactly one CLK cycle.
- Filter: on each CE edge, P <= {P[L_BIT-2:0], S_IN}. Let Pn denote that next value.
- Press: if KEY_EN=0 and Pn is all ones, then at the same edge KEY_EN <= 1 and KEY_UP <= 1.
- Release: if KEY_EN=1 and Pn is all zeros, then KEY_EN <= 0 and KEY_DN <= 1.
- Hysteresis: mixed Pn values hold KEY_EN unchanged.
- Toggle: in MODE 01, KEY_TGL flips at each press edge. In other modes KEY_TGL holds its value.
- MODE is sampled per channel at its press edge only. Changes while a key is held take effect at the next press.
- FSM per channel, with states IDLE, HOLD, DLY, RPT:
  - IDLE -> press with MODE 00/01 -> HOLD.
  - IDLE -> press with MODE 10 -> RPT, cnt <= 0.
  - IDLE -> press with MODE 11 -> DLY, cnt <= 0.
  - In DLY or RPT, at each later CE edge while held: if cnt == LIM-1, then KEY_UP <= 1, cnt <= 0, and next state is RPT. Otherwise cnt++. LIM is DLY_CNT in DLY and RPT_CNT in RPT.
  - Any state -> release -> IDLE, cnt <= 0.
- Resulting repeat timing, counted in CE ticks from the press tick (tick 0): mode 11 pulses at 0, DLY_CNT, DLY_CNT+RPT_CNT, ...; mode 10 pulses at 0, RPT_CNT, 2*RPT_CNT, ...
- Release and repeat-terminal on the same edge: release wins. KEY_DN=1, KEY_UP=0, FSM goes to IDLE.
- Press and release cannot coincide, since Pn cannot be both all ones and all zeros.
- Reset mid-hold: all state is lost. With S_IN still 1, a fresh press (KEY_UP) occurs L_BIT CE ticks after CLR deasserts.
- Channels are fully independent. The counter is CNT_W bits and never wraps, because it is reloaded at LIM-1.

Decomposition:
- Shared package/include holds the MODE encodings (MODE_PLAIN, MODE_TGL, MODE_RPT, MODE_RPTD) and the FSM state encodings.
- Natural sub-module: key_chan_fsm (one channel: filter, hysteresis, FSM, counter, pulse registers). The top generates N_CH instances and shares CLK, CLR, CE and MODE.

Test Plan:
1. Filter: CE=1 every cycle, S_IN[0] driven 1,1,0,1,1,1,1 -> no press during the 1,1,0 glitch; KEY_EN[0] and KEY_UP[0] rise at the 4th consecutive 1 edge; KEY_UP is high for exactly 1 cycle; other channels stay 0.
2. Hysteresis/release: held key, single 0 glitch -> KEY_EN stays 1 and no KEY_DN; then 4 zeros -> KEY_EN falls with one KEY_DN pulse at the 4th-zero edge.
3. Toggle: MODE=01, three clean presses -> KEY_TGL 1,0,1 and three KEY_UP pulses; switching to MODE=00 -> KEY_TGL frozen.
4. Repeat with delay: MODE=11, CE every 4 CLKs, hold 20 ticks past the press -> KEY_UP at ticks 0,8,11,14,17,20 (6 pulses). MODE=10 -> ticks 0,3,6,...,18.
5. Release at the terminal tick: MODE=11, final zero shifted in at tick 8 -> KEY_DN=1, KEY_UP=0, FSM in IDLE; a later press restarts the delay at 8 ticks.
6. Async reset mid-hold: assert CLR between edges -> all outputs 0 immediately; release CLR with S_IN=1 -> KEY_UP after exactly 4 CE ticks; channel 1 pressed concurrently with a different phase gives independent timing.
